// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage: FSM states, widths,
// architectural register codes and the stage-register layout.
package wb_pkg;

   localparam int DATA_W    = 64;
   localparam int REG_IDX_W = 4;
   localparam int RIP_W     = 64;
   localparam int CNT_W     = 64;

   localparam logic [REG_IDX_W-1:0] REG_RAX = 4'd0;
   localparam logic [REG_IDX_W-1:0] REG_RDX = 4'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COMMIT = 2'd1,
      ST_STORE  = 2'd2,
      ST_HALTED = 2'd3
   } wb_state_t;

   // The kill flag is not kept here: it is consumed by the state transition.
   typedef struct packed {
      logic [RIP_W-1:0]     rip;
      logic [REG_IDX_W-1:0] dest_reg;
      logic                 dest_reg_valid;
      logic [DATA_W-1:0]    alu_result;
      logic [REG_IDX_W-1:0] dest_special;
      logic                 dest_special_valid;
      logic [DATA_W-1:0]    alu_result_special;
      logic                 mem_dest;
      logic [DATA_W-1:0]    mem_addr;
   } wb_entry_t;

   function automatic wb_state_t capture_state(input logic kill, input logic mem_dest);
      if (kill)
         return ST_HALTED;
      if (mem_dest)
         return ST_STORE;
      return ST_COMMIT;
   endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Store request/acknowledge bus between the writeback stage and memory.
interface writeback_stage_if
#(
   parameter int DATA_W = wb_pkg::DATA_W
);
   logic              storeReqOut;
   logic [DATA_W-1:0] storeAddrOut;
   logic [DATA_W-1:0] storeDataOut;
   logic              storeAckIn;

   modport master (
      output storeReqOut,
      output storeAddrOut,
      output storeDataOut,
      input  storeAckIn
   );

   modport slave (
      input  storeReqOut,
      input  storeAddrOut,
      input  storeDataOut,
      output storeAckIn
   );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires executed instructions into the regfile (two
// write ports), performs memory stores over req/ack, and halts on a kill.
module writeback_stage
#(
   parameter int DATA_W    = wb_pkg::DATA_W,
   parameter int REG_IDX_W = wb_pkg::REG_IDX_W
)
(
   input  logic                 clk,
   input  logic                 reset,

   input  logic                 exValidIn,
   input  logic                 killIn,
   input  logic [63:0]          ripIn,
   input  logic [REG_IDX_W-1:0] destRegIn,
   input  logic                 destRegValidIn,
   input  logic [DATA_W-1:0]    aluResultIn,
   input  logic [REG_IDX_W-1:0] destRegSpecialIn,
   input  logic                 destRegSpecialValidIn,
   input  logic [DATA_W-1:0]    aluResultSpecialIn,
   input  logic                 isMemoryAccessDestIn,
   input  logic [DATA_W-1:0]    memoryAddressDestIn,

   writeback_stage_if.master    store_if,

   output logic                 regWrEnOut,
   output logic [REG_IDX_W-1:0] regWrIdxOut,
   output logic [DATA_W-1:0]    regWrDataOut,
   output logic                 regWr2EnOut,
   output logic [REG_IDX_W-1:0] regWr2IdxOut,
   output logic [DATA_W-1:0]    regWr2DataOut,
   output logic                 wbStallOut,
   output logic                 haltOut,
   output logic [63:0]          retiredRipOut,
   output logic [63:0]          retiredCountOut
);
   import wb_pkg::*;

   wb_state_t  r_state;
   wb_state_t  w_state_next;
   wb_entry_t  r_entry;
   wb_entry_t  w_entry_in;
   logic [CNT_W-1:0] r_retired_count;
   logic [RIP_W-1:0] r_retired_rip;

   logic       w_capture;
   logic       w_retire;
   logic       w_kill_retire;
   logic [1:0] w_retire_inc;
   logic       w_wr_en;
   logic       w_wr2_en;
   logic       w_store_req;
   logic       w_stall;

   always_comb begin
      w_entry_in                    = '0;
      w_entry_in.rip                = ripIn;
      w_entry_in.dest_reg           = destRegIn;
      w_entry_in.dest_reg_valid     = destRegValidIn;
      w_entry_in.alu_result         = aluResultIn;
      w_entry_in.dest_special       = destRegSpecialIn;
      w_entry_in.dest_special_valid = destRegSpecialValidIn;
      w_entry_in.alu_result_special = aluResultSpecialIn;
      w_entry_in.mem_dest           = isMemoryAccessDestIn;
      w_entry_in.mem_addr           = memoryAddressDestIn;
   end

   // Next state and retire/write decode. Capture is only possible from IDLE
   // or COMMIT, which is exactly when the stall output is low.
   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_retire     = 1'b0;
      w_wr_en      = 1'b0;
      w_wr2_en     = 1'b0;
      w_store_req  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_capture = exValidIn;
         end
         ST_COMMIT: begin
            w_retire     = 1'b1;
            w_capture    = exValidIn;
            w_wr_en      = r_entry.dest_reg_valid && !r_entry.mem_dest;
            w_wr2_en     = r_entry.dest_special_valid;
            w_state_next = ST_IDLE;
         end
         ST_STORE: begin
            w_store_req = 1'b1;
            if (store_if.storeAckIn) begin
               w_retire     = 1'b1;
               w_wr2_en     = r_entry.dest_special_valid;
               w_state_next = ST_IDLE;
            end
         end
         ST_HALTED: begin
            w_state_next = ST_HALTED;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
      if (w_capture)
         w_state_next = capture_state(killIn, isMemoryAccessDestIn);
   end

   // A kill retires on the edge that captures it; it may coincide with the
   // retire of a committing predecessor, hence the two-bit increment.
   assign w_kill_retire = w_capture && killIn;
   assign w_retire_inc  = {1'b0, w_retire} + {1'b0, w_kill_retire};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_entry         <= '0;
         r_retired_count <= '0;
         r_retired_rip   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_capture)
            r_entry <= w_entry_in;
         if (w_retire || w_kill_retire) begin
            r_retired_count <= r_retired_count + {{(CNT_W-2){1'b0}}, w_retire_inc};
            r_retired_rip   <= w_kill_retire ? ripIn : r_entry.rip;
         end
      end
   end

   assign w_stall = (r_state == ST_STORE) || (r_state == ST_HALTED);

   assign regWrEnOut      = w_wr_en;
   assign regWrIdxOut     = r_entry.dest_reg;
   assign regWrDataOut    = r_entry.alu_result;
   assign regWr2EnOut     = w_wr2_en;
   assign regWr2IdxOut    = r_entry.dest_special;
   assign regWr2DataOut   = r_entry.alu_result_special;

   assign store_if.storeReqOut  = w_store_req;
   assign store_if.storeAddrOut = r_entry.mem_addr;
   assign store_if.storeDataOut = r_entry.alu_result;

   assign wbStallOut      = w_stall;
   assign haltOut         = (r_state == ST_HALTED);
   assign retiredRipOut   = r_retired_rip;
   assign retiredCountOut = r_retired_count;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, hand-written multi-cycle
// sequences, and a randomized stream checked against an event-level model.
module tb_writeback_stage;
   import wb_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        exValidIn, killIn;
   logic [63:0] ripIn;
   logic [3:0]  destRegIn, destRegSpecialIn;
   logic        destRegValidIn, destRegSpecialValidIn, isMemoryAccessDestIn;
   logic [63:0] aluResultIn, aluResultSpecialIn, memoryAddressDestIn;
   logic        regWrEnOut, regWr2EnOut, wbStallOut, haltOut;
   logic [3:0]  regWrIdxOut, regWr2IdxOut;
   logic [63:0] regWrDataOut, regWr2DataOut, retiredRipOut, retiredCountOut;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   writeback_stage_if #(.DATA_W(64)) store_if ();

   writeback_stage #(.DATA_W(64), .REG_IDX_W(4)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .exValidIn             (exValidIn),
      .killIn                (killIn),
      .ripIn                 (ripIn),
      .destRegIn             (destRegIn),
      .destRegValidIn        (destRegValidIn),
      .aluResultIn           (aluResultIn),
      .destRegSpecialIn      (destRegSpecialIn),
      .destRegSpecialValidIn (destRegSpecialValidIn),
      .aluResultSpecialIn    (aluResultSpecialIn),
      .isMemoryAccessDestIn  (isMemoryAccessDestIn),
      .memoryAddressDestIn   (memoryAddressDestIn),
      .store_if              (store_if),
      .regWrEnOut            (regWrEnOut),
      .regWrIdxOut           (regWrIdxOut),
      .regWrDataOut          (regWrDataOut),
      .regWr2EnOut           (regWr2EnOut),
      .regWr2IdxOut          (regWr2IdxOut),
      .regWr2DataOut         (regWr2DataOut),
      .wbStallOut            (wbStallOut),
      .haltOut               (haltOut),
      .retiredRipOut         (retiredRipOut),
      .retiredCountOut       (retiredCountOut)
   );

   typedef struct {
      logic [63:0] rip;
      logic [3:0]  dest;
      logic        dv;
      logic [63:0] res;
      logic [3:0]  sdest;
      logic        sv;
      logic [63:0] sres;
      logic        mem;
      logic [63:0] addr;
      logic        kill;
   } instr_t;

   typedef struct {
      instr_t      in;
      logic        e_wr;
      logic [3:0]  e_idx;
      logic [63:0] e_data;
      logic        e_wr2;
      logic [3:0]  e_idx2;
      logic [63:0] e_data2;
      logic        e_req;
      logic [63:0] e_addr;
      logic [63:0] e_sdata;
      logic        e_stall;
   } vec_t;

   typedef struct {
      logic        port;
      logic [3:0]  idx;
      logic [63:0] data;
   } wr_ev_t;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
   } st_ev_t;

   function automatic instr_t mk(input logic [63:0] rip, input logic [3:0] dest, input logic dv,
                                 input logic [63:0] res, input logic [3:0] sdest, input logic sv,
                                 input logic [63:0] sres, input logic mem, input logic [63:0] addr,
                                 input logic kill);
      instr_t i;
      i.rip = rip; i.dest = dest; i.dv = dv; i.res = res; i.sdest = sdest; i.sv = sv;
      i.sres = sres; i.mem = mem; i.addr = addr; i.kill = kill;
      return i;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input instr_t i, input logic valid);
      exValidIn             = valid;
      killIn                = i.kill;
      ripIn                 = i.rip;
      destRegIn             = i.dest;
      destRegValidIn        = i.dv;
      aluResultIn           = i.res;
      destRegSpecialIn      = i.sdest;
      destRegSpecialValidIn = i.sv;
      aluResultSpecialIn    = i.sres;
      isMemoryAccessDestIn  = i.mem;
      memoryAddressDestIn   = i.addr;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      exValidIn = 1'b0;
      store_if.storeAckIn = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   vec_t   vecs[6];
   instr_t rnd[40];
   wr_ev_t exp_wr[$], act_wr[$];
   st_ev_t exp_st[$], act_st[$];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [63:0] exp_count;
      instr_t      nop_i;
      instr_t      seq[3];
      instr_t      st_i, add_i, kill_i;

      reset = 1'b1;
      nop_i = mk(64'h0, 4'h0, 1'b0, 64'h0, 4'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      drive(nop_i, 1'b0);
      store_if.storeAckIn = 1'b0;

      // Directed vectors applied one at a time from IDLE; ack is held high from
      // before capture, so it is also presented while no request is pending.
      vecs[0] = '{mk(64'h100, 4'd3, 1, 64'h5, 4'd0, 0, 64'h0, 0, 64'h0, 0),
                  1, 4'd3, 64'h5, 0, 4'd0, 64'h0, 0, 64'h0, 64'h0, 0};
      vecs[1] = '{mk(64'h104, REG_RAX, 1, 64'h1, REG_RDX, 1, 64'h2, 0, 64'h0, 0),
                  1, 4'd0, 64'h1, 1, 4'd2, 64'h2, 0, 64'h0, 64'h0, 0};
      vecs[2] = '{mk(64'h108, 4'd7, 0, 64'h77, 4'd9, 0, 64'h99, 0, 64'h0, 0),
                  0, 4'd0, 64'h0, 0, 4'd0, 64'h0, 0, 64'h0, 64'h0, 0};
      vecs[3] = '{mk(64'h10C, 4'd4, 1, 64'hDEAD, 4'd0, 0, 64'h0, 1, 64'h1000, 0),
                  0, 4'd0, 64'h0, 0, 4'd0, 64'h0, 1, 64'h1000, 64'hDEAD, 1};
      vecs[4] = '{mk(64'h110, 4'd1, 0, 64'hBEEF, REG_RDX, 1, 64'hCAFE, 1, 64'h2008, 0),
                  0, 4'd0, 64'h0, 1, 4'd2, 64'hCAFE, 1, 64'h2008, 64'hBEEF, 1};
      vecs[5] = '{mk(64'h114, 4'd5, 1, 64'h11, 4'd5, 1, 64'h22, 0, 64'h0, 0),
                  1, 4'd5, 64'h11, 1, 4'd5, 64'h22, 0, 64'h0, 64'h0, 0};

      do_reset();
      #1;
      check("rst_wr_en",  {63'd0, regWrEnOut}, 64'd0);
      check("rst_wr2_en", {63'd0, regWr2EnOut}, 64'd0);
      check("rst_wr_data", regWrDataOut, 64'd0);
      check("rst_req",    {63'd0, store_if.storeReqOut}, 64'd0);
      check("rst_addr",   store_if.storeAddrOut, 64'd0);
      check("rst_stall",  {63'd0, wbStallOut}, 64'd0);
      check("rst_halt",   {63'd0, haltOut}, 64'd0);
      check("rst_rip",    retiredRipOut, 64'd0);
      check("rst_count",  retiredCountOut, 64'd0);
      $display("[TB] reset state checked");

      exp_count = 64'd0;
      for (int v = 0; v < 6; v++) begin
         @(negedge clk);
         drive(vecs[v].in, 1'b1);
         store_if.storeAckIn = 1'b1;
         @(posedge clk);
         @(negedge clk);
         exValidIn = 1'b0;
         #1;
         check($sformatf("vec%0d_wr_en", v), {63'd0, regWrEnOut}, {63'd0, vecs[v].e_wr});
         check($sformatf("vec%0d_wr2_en", v), {63'd0, regWr2EnOut}, {63'd0, vecs[v].e_wr2});
         check($sformatf("vec%0d_req", v), {63'd0, store_if.storeReqOut}, {63'd0, vecs[v].e_req});
         check($sformatf("vec%0d_stall", v), {63'd0, wbStallOut}, {63'd0, vecs[v].e_stall});
         if (vecs[v].e_wr) begin
            check($sformatf("vec%0d_wr_idx", v), {60'd0, regWrIdxOut}, {60'd0, vecs[v].e_idx});
            check($sformatf("vec%0d_wr_data", v), regWrDataOut, vecs[v].e_data);
         end
         if (vecs[v].e_wr2) begin
            check($sformatf("vec%0d_wr2_idx", v), {60'd0, regWr2IdxOut}, {60'd0, vecs[v].e_idx2});
            check($sformatf("vec%0d_wr2_data", v), regWr2DataOut, vecs[v].e_data2);
         end
         if (vecs[v].e_req) begin
            check($sformatf("vec%0d_st_addr", v), store_if.storeAddrOut, vecs[v].e_addr);
            check($sformatf("vec%0d_st_data", v), store_if.storeDataOut, vecs[v].e_sdata);
         end
         @(posedge clk);
         @(negedge clk);
         store_if.storeAckIn = 1'b0;
         exp_count++;
         #1;
         check($sformatf("vec%0d_count", v), retiredCountOut, exp_count);
         check($sformatf("vec%0d_rip", v), retiredRipOut, vecs[v].in.rip);
         check($sformatf("vec%0d_stall_after", v), {63'd0, wbStallOut}, 64'd0);
         $display("[TB] vector %0d rip 0x%0h applied", v, vecs[v].in.rip);
      end

      // Three back-to-back register instructions: one write per cycle, no stall.
      for (int k = 0; k < 3; k++)
         seq[k] = mk(64'h200 + 64'(4*k), 4'(k + 8), 1, 64'hA0 + 64'(k), 4'd0, 0, 64'h0, 0, 64'h0, 0);
      @(negedge clk);
      drive(seq[0], 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k < 2) drive(seq[k+1], 1'b1);
         else exValidIn = 1'b0;
         #1;
         check($sformatf("b2b%0d_wr_en", k), {63'd0, regWrEnOut}, 64'd1);
         check($sformatf("b2b%0d_wr_data", k), regWrDataOut, seq[k].res);
         check($sformatf("b2b%0d_stall", k), {63'd0, wbStallOut}, 64'd0);
         $display("[TB] back-to-back write %0d data 0x%0h", k, seq[k].res);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      exp_count += 3;
      check("b2b_count", retiredCountOut, exp_count);
      check("b2b_idle_wr_en", {63'd0, regWrEnOut}, 64'd0);

      // Store with ack delayed 3 cycles; the next instruction waits it out.
      st_i  = mk(64'h300, 4'd0, 0, 64'hDEAD, 4'd0, 0, 64'h0, 1, 64'h1000, 0);
      add_i = mk(64'h304, 4'd6, 1, 64'h66, 4'd0, 0, 64'h0, 0, 64'h0, 0);
      @(negedge clk);
      drive(st_i, 1'b1);
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive(add_i, 1'b1);
         store_if.storeAckIn = (k == 3);
         #1;
         check($sformatf("st%0d_req", k), {63'd0, store_if.storeReqOut}, 64'd1);
         check($sformatf("st%0d_addr", k), store_if.storeAddrOut, 64'h1000);
         check($sformatf("st%0d_data", k), store_if.storeDataOut, 64'hDEAD);
         check($sformatf("st%0d_stall", k), {63'd0, wbStallOut}, 64'd1);
         check($sformatf("st%0d_wr_en", k), {63'd0, regWrEnOut}, 64'd0);
         @(posedge clk);
      end
      @(negedge clk);
      store_if.storeAckIn = 1'b0;
      #1;
      exp_count++;
      check("st_after_req", {63'd0, store_if.storeReqOut}, 64'd0);
      check("st_after_wr_en", {63'd0, regWrEnOut}, 64'd0);
      check("st_after_count", retiredCountOut, exp_count);
      $display("[TB] delayed store to 0x1000 retired");
      @(posedge clk);
      @(negedge clk);
      exValidIn = 1'b0;
      #1;
      check("st_next_wr_en", {63'd0, regWrEnOut}, 64'd1);
      check("st_next_wr_data", regWrDataOut, 64'h66);
      @(posedge clk);
      @(negedge clk);
      #1;
      exp_count++;
      check("st_next_count", retiredCountOut, exp_count);

      // Kill after two ADDs; later instructions must be ignored.
      do_reset();
      kill_i = mk(64'h4F0, 4'd1, 1, 64'h1, 4'd2, 1, 64'h2, 0, 64'h0, 1);
      @(negedge clk);
      drive(seq[0], 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(seq[1], 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(kill_i, 1'b1);
      @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive(seq[2], 1'b1);
         store_if.storeAckIn = 1'b1;
         #1;
         check($sformatf("kill%0d_halt", k), {63'd0, haltOut}, 64'd1);
         check($sformatf("kill%0d_stall", k), {63'd0, wbStallOut}, 64'd1);
         check($sformatf("kill%0d_wr", k), {62'd0, regWrEnOut, regWr2EnOut}, 64'd0);
         check($sformatf("kill%0d_req", k), {63'd0, store_if.storeReqOut}, 64'd0);
         check($sformatf("kill%0d_count", k), retiredCountOut, 64'd3);
         @(posedge clk);
      end
      check("kill_rip", retiredRipOut, 64'h4F0);
      $display("[TB] kill sequence halted with count %0d", retiredCountOut);
      do_reset();
      #1;
      check("kill_rst_halt", {63'd0, haltOut}, 64'd0);
      check("kill_rst_stall", {63'd0, wbStallOut}, 64'd0);
      check("kill_rst_count", retiredCountOut, 64'd0);

      // Reset while a store is waiting for its ack.
      @(negedge clk);
      drive(st_i, 1'b1);
      @(posedge clk);
      @(negedge clk);
      exValidIn = 1'b0;
      #1;
      check("rststore_req_before", {63'd0, store_if.storeReqOut}, 64'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rststore_req", {63'd0, store_if.storeReqOut}, 64'd0);
      check("rststore_count", retiredCountOut, 64'd0);
      check("rststore_stall", {63'd0, wbStallOut}, 64'd0);
      reset = 1'b0;
      $display("[TB] reset during store dropped request");

      // Randomized stream against an event-level model.
      do_reset();
      for (int n = 0; n < 40; n++) begin
         int kind;
         kind = int'($urandom_range(0, 9));
         rnd[n] = mk(64'h8000 + 64'(n * 4), 4'($urandom), ($urandom_range(0, 4) != 0),
                     {$urandom, $urandom}, 4'($urandom), ($urandom_range(0, 3) == 0),
                     {$urandom, $urandom}, (kind < 3), {$urandom, $urandom}, (n == 39));
      end
      foreach (rnd[n]) begin
         if (rnd[n].kill) break;
         if (rnd[n].mem) exp_st.push_back('{rnd[n].addr, rnd[n].res});
         else if (rnd[n].dv) exp_wr.push_back('{1'b0, rnd[n].dest, rnd[n].res});
         if (rnd[n].sv) exp_wr.push_back('{1'b1, rnd[n].sdest, rnd[n].sres});
      end
      begin
         int  ip = 0, drain = 0, cyc = 0, ack_wait;
         logic presenting = 1'b0;
         logic stall_s;
         ack_wait = int'($urandom_range(0, 3));
         while (cyc < 3000 && drain < 8) begin
            @(negedge clk);
            if (!presenting) begin
               if (ip < 40 && $urandom_range(0, 3) != 0) begin
                  drive(rnd[ip], 1'b1);
                  presenting = 1'b1;
               end else begin
                  drive(mk({$urandom, $urandom}, 4'($urandom), 1, {$urandom, $urandom},
                           4'($urandom), 1, 64'h0, 1, 64'h0, 1), 1'b0);
               end
            end
            if (store_if.storeReqOut) begin
               if (ack_wait == 0) begin
                  store_if.storeAckIn = 1'b1;
                  ack_wait = int'($urandom_range(0, 3));
               end else begin
                  store_if.storeAckIn = 1'b0;
                  ack_wait--;
               end
            end else begin
               store_if.storeAckIn = 1'($urandom_range(0, 1));
            end
            #1;
            if (regWrEnOut) act_wr.push_back('{1'b0, regWrIdxOut, regWrDataOut});
            if (regWr2EnOut) act_wr.push_back('{1'b1, regWr2IdxOut, regWr2DataOut});
            if (store_if.storeReqOut && store_if.storeAckIn)
               act_st.push_back('{store_if.storeAddrOut, store_if.storeDataOut});
            stall_s = wbStallOut;
            @(posedge clk);
            if (presenting && !stall_s) begin
               presenting = 1'b0;
               ip++;
            end
            if (ip == 40) drain++;
            cyc++;
         end
         n_tests++;
         if (ip != 40) begin
            n_fail++;
            $display("FAIL rand_timeout: accepted %0d, expected 40", ip);
         end
      end
      @(negedge clk);
      exValidIn = 1'b0;
      store_if.storeAckIn = 1'b0;
      #1;
      check("rand_wr_events", 64'(act_wr.size()), 64'(exp_wr.size()));
      check("rand_st_events", 64'(act_st.size()), 64'(exp_st.size()));
      for (int e = 0; e < exp_wr.size() && e < act_wr.size(); e++) begin
         check($sformatf("rand_wr%0d_port", e), {63'd0, act_wr[e].port}, {63'd0, exp_wr[e].port});
         check($sformatf("rand_wr%0d_idx", e), {60'd0, act_wr[e].idx}, {60'd0, exp_wr[e].idx});
         check($sformatf("rand_wr%0d_data", e), act_wr[e].data, exp_wr[e].data);
         $display("[TB] rand write %0d port %0d idx %0d data 0x%0h", e, exp_wr[e].port,
                  exp_wr[e].idx, exp_wr[e].data);
      end
      for (int e = 0; e < exp_st.size() && e < act_st.size(); e++) begin
         check($sformatf("rand_st%0d_addr", e), act_st[e].addr, exp_st[e].addr);
         check($sformatf("rand_st%0d_data", e), act_st[e].data, exp_st[e].data);
         $display("[TB] rand store %0d addr 0x%0h data 0x%0h", e, exp_st[e].addr, exp_st[e].data);
      end
      check("rand_count", retiredCountOut, 64'd40);
      check("rand_rip", retiredRipOut, rnd[39].rip);
      check("rand_halt", {63'd0, haltOut}, 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
